// File: rtl/fpnew_result_queue.sv
// In-order result queue behind the FPnew wrapper: buffers results, issues
// issue credits so every issued op has a reserved slot, and keeps sticky fflags.
module fpnew_result_queue #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 2,
  parameter int DEPTH     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         issue_fire_i,
  output logic                         issue_credit_o,
  input  logic                         flush_i,
  input  logic                         fpu_valid_i,
  output logic                         fpu_ready_o,
  input  logic [WIDTH-1:0]             fpu_result_i,
  input  logic [4:0]                   fpu_status_i,
  input  logic [TAG_WIDTH-1:0]         fpu_tag_i,
  output logic                         deq_valid_o,
  input  logic                         deq_ready_i,
  output logic [WIDTH-1:0]             deq_result_o,
  output logic [4:0]                   deq_status_o,
  output logic [TAG_WIDTH-1:0]         deq_tag_o,
  output logic [4:0]                   flags_o,
  input  logic                         flags_clear_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [$clog2(DEPTH+1)-1:0]   inflight_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_CW = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0]     result;
    logic [4:0]           status;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count, inflight;
  logic [4:0]    flags;

  logic          enq, deq, enq_acc, deq_acc;
  logic [CW:0]   occupancy, count_sum, inflight_sum;
  logic [4:0]    flags_d;
  entry_t        head;

  assign head         = mem[rptr];
  assign deq_result_o = head.result;
  assign deq_status_o = head.status;
  assign deq_tag_o    = head.tag;
  assign deq_valid_o  = (count != '0);

  // Ready depends only on registered occupancy (and flush), never on deq_ready_i.
  assign fpu_ready_o    = (count != DEPTH_C) | flush_i;
  assign occupancy      = {1'b0, inflight} + {1'b0, count};
  assign issue_credit_o = (occupancy < DEPTH_CW);

  assign enq     = fpu_valid_i & fpu_ready_o;
  assign deq     = deq_valid_o & deq_ready_i;
  assign enq_acc = enq & ~flush_i;
  assign deq_acc = deq & ~flush_i;

  assign count_sum    = {1'b0, count} + (CW+1)'(enq_acc) - (CW+1)'(deq_acc);
  assign inflight_sum = {1'b0, inflight} + (CW+1)'(issue_fire_i) - (CW+1)'(enq_acc);

  // Clear is applied before the retiring status is ORed in.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    flags_d = flags;
    if (flags_clear_i) flags_d = '0;
    if (deq_acc)       flags_d = flags_d | deq_status_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_ni) begin
      count    <= '0;
      inflight <= '0;
      rptr     <= '0;
      wptr     <= '0;
      flags    <= '0;
    end else begin
      flags <= flags_d;
      if (flush_i) begin
        count    <= '0;
        inflight <= '0;
        rptr     <= '0;
        wptr     <= '0;
      end else begin
        count    <= count_sum[CW-1:0];
        inflight <= inflight_sum[CW-1:0];
        if (enq_acc) wptr <= wptr + PW'(1);
        if (deq_acc) rptr <= rptr + PW'(1);
      end
    end
  end

  // NOTE: storage is not reset; count gates deq_valid_o, so stale entries are never seen.
  always_ff @(posedge clk_i) begin
    if (enq_acc) mem[wptr] <= '{result: fpu_result_i, status: fpu_status_i, tag: fpu_tag_i};
  end

  assign flags_o    = flags;
  assign count_o    = count;
  assign inflight_o = inflight;

  // Upstream protocol checks; flush cycles are exempt since they discard everything.
  a_no_orphan_result: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fpu_valid_i && !flush_i && inflight == '0 && !issue_fire_i));
  a_no_issue_without_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(issue_fire_i && !flush_i && !issue_credit_o));
  a_no_counter_wrap: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(count_sum[CW] || inflight_sum[CW]));

endmodule

// File: tb/tb_fpnew_result_queue.sv
// Directed + randomized bench for fpnew_result_queue against a queue-based
// reference model of occupancy, in-flight ops and sticky flags.
module tb_fpnew_result_queue;

  localparam int WIDTH = 64;
  localparam int TW    = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [4:0]       status;
    logic [TW-1:0]    tag;
  } entry_t;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             issue_fire_i, issue_credit_o, flush_i;
  logic             fpu_valid_i, fpu_ready_o;
  logic [WIDTH-1:0] fpu_result_i;
  logic [4:0]       fpu_status_i;
  logic [TW-1:0]    fpu_tag_i;
  logic             deq_valid_o, deq_ready_i;
  logic [WIDTH-1:0] deq_result_o;
  logic [4:0]       deq_status_o;
  logic [TW-1:0]    deq_tag_o;
  logic [4:0]       flags_o;
  logic             flags_clear_i;
  logic [2:0]       count_o, inflight_o;

  fpnew_result_queue #(.WIDTH(WIDTH), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_fire_i(issue_fire_i), .issue_credit_o(issue_credit_o), .flush_i(flush_i),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_result_o(deq_result_o), .deq_status_o(deq_status_o), .deq_tag_o(deq_tag_o),
    .flags_o(flags_o), .flags_clear_i(flags_clear_i),
    .count_o(count_o), .inflight_o(inflight_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: results waiting in the queue, ops in flight, sticky flags.
  entry_t   m_q[$];
  int       m_inflight;
  bit [4:0] m_flags;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},    64'(count_o),        64'(m_q.size()));
    chk({tag, ".inflight"}, 64'(inflight_o),     64'(m_inflight));
    chk({tag, ".dvalid"},   64'(deq_valid_o),    64'(m_q.size() != 0));
    chk({tag, ".credit"},   64'(issue_credit_o), 64'(m_inflight + m_q.size() < DEPTH));
    chk({tag, ".fready"},   64'(fpu_ready_o),    64'(m_q.size() < DEPTH || flush_i));
    chk({tag, ".flags"},    64'(flags_o),        64'(m_flags));
    if (m_q.size() != 0) begin
      chk({tag, ".result"}, deq_result_o,        m_q[0].result);
      chk({tag, ".status"}, 64'(deq_status_o),   64'(m_q[0].status));
      chk({tag, ".tag"},    64'(deq_tag_o),      64'(m_q[0].tag));
    end
  endtask

  task automatic set_idle();
    issue_fire_i  = 1'b0;
    flush_i       = 1'b0;
    fpu_valid_i   = 1'b0;
    fpu_result_i  = '0;
    fpu_status_i  = '0;
    fpu_tag_i     = '0;
    deq_ready_i   = 1'b0;
    flags_clear_i = 1'b0;
  endtask

  // One clock with the currently driven inputs; model updated from the spec rules.
  task automatic tick(input string tag);
    bit     enq, deq, fl, clr, iss;
    entry_t e;
    enq = fpu_valid_i && (m_q.size() < DEPTH || flush_i);
    deq = deq_ready_i && m_q.size() != 0;
    fl  = flush_i;
    clr = flags_clear_i;
    iss = issue_fire_i;
    e   = '{result: fpu_result_i, status: fpu_status_i, tag: fpu_tag_i};
    @(posedge clk_i); #1;
    if (clr) m_flags = '0;
    if (fl) begin
      m_q.delete();
      m_inflight = 0;
    end else begin
      if (deq) begin
        m_flags = m_flags | m_q[0].status;
        void'(m_q.pop_front());
      end
      if (enq) m_q.push_back(e);
      m_inflight = m_inflight + int'(iss) - int'(enq);
    end
    check_all(tag);
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      issue_fire_i = 1'b1;
      tick("issue");
    end
    issue_fire_i = 1'b0;
  endtask

  task automatic ret(input logic [63:0] r, input logic [4:0] s, input logic [1:0] t);
    fpu_valid_i = 1'b1; fpu_result_i = r; fpu_status_i = s; fpu_tag_i = t;
    tick("ret");
    fpu_valid_i = 1'b0;
  endtask

  task automatic drain(input int n);
    deq_ready_i = 1'b1;
    for (int i = 0; i < n; i++) tick("drain");
    deq_ready_i = 1'b0;
  endtask

  entry_t   arr[10];
  bit [4:0] saved_flags;

  initial begin
    set_idle();
    rst_ni = 1'b0;
    m_inflight = 0; m_flags = '0;
    #1;
    check_all("reset");
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Basic: one op, result visible the cycle after it is accepted.
    issue_n(1);
    chk("basic.inflight1", 64'(inflight_o), 64'd1);
    deq_ready_i = 1'b1;
    ret(64'h3FF0000000000000, 5'b00001, 2'd2);
    chk("basic.dvalid", 64'(deq_valid_o), 64'd1);
    chk("basic.data",   deq_result_o, 64'h3FF0000000000000);
    chk("basic.cnt1",   64'(count_o), 64'd1);
    tick("basic.deq");
    deq_ready_i = 1'b0;
    chk("basic.cnt0",   64'(count_o), 64'd0);
    chk("basic.flags",  64'(flags_o), 64'b00001);

    // Credit exhaustion.
    issue_n(DEPTH);
    chk("credit.zero", 64'(issue_credit_o), 64'd0);
    for (int i = 0; i < DEPTH; i++)
      ret({$urandom, $urandom}, 5'(i), 2'(i));
    chk("credit.full",  64'(count_o), 64'd4);
    chk("credit.ready", 64'(fpu_ready_o), 64'd0);
    chk("credit.infl",  64'(inflight_o), 64'd0);
    deq_ready_i = 1'b1;
    tick("credit.deq1");
    deq_ready_i = 1'b0;
    chk("credit.back", 64'(issue_credit_o), 64'd1);
    drain(DEPTH - 1);

    // Order and wrap under random dequeue backpressure.
    begin
      int  issued = 0, sent = 0, got = 0;
      bit  acc = 1'b1;
      for (int i = 0; i < 10; i++)
        arr[i] = '{result: {$urandom, $urandom}, status: 5'($urandom), tag: 2'(i)};
      for (int cyc = 0; cyc < 2000 && got < 10; cyc++) begin
        issue_fire_i = (issued < 10) && (m_inflight + m_q.size() < DEPTH) && ($urandom_range(1) == 1);
        if (!(fpu_valid_i && !acc))
          fpu_valid_i = (m_inflight > 0) && ($urandom_range(1) == 1);
        fpu_result_i = arr[sent % 10].result;
        fpu_status_i = arr[sent % 10].status;
        fpu_tag_i    = arr[sent % 10].tag;
        deq_ready_i  = ($urandom_range(3) != 0);
        acc = fpu_valid_i && (m_q.size() < DEPTH);
        if (deq_ready_i && deq_valid_o) begin
          chk("order.result", deq_result_o,      arr[got].result);
          chk("order.tag",    64'(deq_tag_o),    64'(arr[got].tag));
          got++;
        end
        tick("order");
        if (acc) sent++;
        if (issue_fire_i) issued++;
      end
      chk("order.all_retired", 64'(got), 64'd10);
      set_idle();
      tick("order.idle");
    end

    // Sticky flags.
    flags_clear_i = 1'b1;
    tick("flags.clr");
    flags_clear_i = 1'b0;
    chk("flags.cleared", 64'(flags_o), 64'd0);
    issue_n(2);
    ret(64'h1, 5'b10000, 2'd0);
    ret(64'h2, 5'b00100, 2'd1);
    drain(2);
    chk("flags.sticky", 64'(flags_o), 64'b10100);
    issue_n(1);
    ret(64'h3, 5'b00010, 2'd2);
    deq_ready_i = 1'b1; flags_clear_i = 1'b1;
    tick("flags.clr_deq");
    set_idle();
    chk("flags.clr_deq", 64'(flags_o), 64'b00010);

    // Flush with count=2, inflight=2 and concurrent issue/return/dequeue.
    issue_n(4);
    ret(64'h10, 5'b11111, 2'd0);
    ret(64'h11, 5'b11111, 2'd1);
    chk("flush.pre_cnt", 64'(count_o), 64'd2);
    chk("flush.pre_inf", 64'(inflight_o), 64'd2);
    saved_flags = flags_o;
    flush_i = 1'b1; issue_fire_i = 1'b1; fpu_valid_i = 1'b1; deq_ready_i = 1'b1;
    fpu_result_i = 64'h12; fpu_status_i = 5'b11111;
    tick("flush");
    set_idle();
    chk("flush.cnt",    64'(count_o), 64'd0);
    chk("flush.inf",    64'(inflight_o), 64'd0);
    chk("flush.dvalid", 64'(deq_valid_o), 64'd0);
    chk("flush.credit", 64'(issue_credit_o), 64'd1);
    chk("flush.flags",  64'(flags_o), 64'(saved_flags));

    // Asynchronous reset with three entries queued.
    issue_n(3);
    for (int i = 0; i < 3; i++) ret({$urandom, $urandom}, 5'b01000, 2'(i));
    chk("areset.pre_cnt", 64'(count_o), 64'd3);
    #2 rst_ni = 1'b0;
    #1;
    m_q.delete(); m_inflight = 0; m_flags = '0;
    check_all("areset");
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_all("areset.post");

    // Normal operation after reset.
    issue_n(1);
    ret(64'hCAFE, 5'b00011, 2'd3);
    drain(1);
    chk("post.flags", 64'(flags_o), 64'b00011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
